// File: rtl/sort_engine.sv
// In-place bubble sort peripheral: values are loaded, sorted, then drained in order.
// Latency: one compare/swap per cycle while busy; a drained word is valid combinationally from the read pointer.
// Backpressure: none; strobes outside their phase are dropped and raise the sticky o_err flag.
module sort_engine #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 10,
    parameter bit DESCENDING = 1'b0,
    localparam int CW        = $clog2(DEPTH + 1),
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,      // asynchronous, active low
    input  logic             i_clear,
    input  logic             i_wr_strobe,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_start,
    input  logic             i_rd_strobe,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [CW-1:0]    o_count,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    typedef enum logic [1:0] {ST_LOAD, ST_SORT, ST_DRAIN} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_i;
    logic [CW-1:0]    r_limit;
    logic             r_swapped;
    logic             r_err;

    logic             w_wr_ok;
    logic [CW-1:0]    w_count_wr;
    logic [AW-1:0]    w_i1;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_swap;
    logic             w_pass_end;
    logic             w_sort_exit;
    logic             w_last_pop;

    // A write in LOAD lands first, so a same-cycle start sorts the new word too.
    assign w_wr_ok    = i_wr_strobe && (r_count < CW'(DEPTH));
    assign w_count_wr = r_count + CW'(w_wr_ok);

    // Compare the adjacent pair at r_i; equal values never swap.
    assign w_i1   = r_i + AW'(1);
    assign w_a    = r_mem[r_i];
    assign w_b    = r_mem[w_i1];
    assign w_swap = DESCENDING ? (w_a < w_b) : (w_a > w_b);

    // A pass ends at the last pair below the shrinking limit; a swap-free pass
    // means the buffer is already ordered.
    assign w_pass_end  = (CW'(r_i) == (r_limit - CW'(1)));
    assign w_sort_exit = w_pass_end && (!(r_swapped || w_swap) || (r_limit == CW'(1)));

    // An empty drain (start with no data) also returns on the first pop.
    assign w_last_pop = (r_count == '0) || (r_rd_ptr == (r_count - CW'(1)));

    // State register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= ST_LOAD;
        else          r_state <= w_state_nxt;
    end

    // Next-state and output decode; clear overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_rd_data   = '0;
        case (r_state)
            ST_LOAD: begin
                if (i_start) w_state_nxt = (w_count_wr >= CW'(2)) ? ST_SORT : ST_DRAIN;
            end
            ST_SORT: begin
                o_busy = 1'b1;
                if (w_sort_exit) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                o_done    = 1'b1;
                o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
                if (i_rd_strobe && w_last_pop) w_state_nxt = ST_LOAD;
            end
            default: w_state_nxt = ST_LOAD;
        endcase
        if (i_clear) w_state_nxt = ST_LOAD;
    end

    // Control counters, pass bookkeeping and the sticky error flag.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_count   <= '0;
            r_rd_ptr  <= '0;
            r_i       <= '0;
            r_limit   <= '0;
            r_swapped <= 1'b0;
            r_err     <= 1'b0;
        end else if (i_clear) begin
            r_count   <= '0;
            r_rd_ptr  <= '0;
            r_i       <= '0;
            r_limit   <= '0;
            r_swapped <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_count  <= w_count_wr;
                    r_rd_ptr <= '0;
                    if (i_wr_strobe && !w_wr_ok) r_err <= 1'b1;
                    if (i_start && (w_count_wr >= CW'(2))) begin
                        r_i       <= '0;
                        r_limit   <= w_count_wr - CW'(1);
                        r_swapped <= 1'b0;
                    end
                end
                ST_SORT: begin
                    if (i_wr_strobe || i_start || i_rd_strobe) r_err <= 1'b1;
                    if (w_pass_end) begin
                        if (!w_sort_exit) begin
                            r_limit   <= r_limit - CW'(1);
                            r_i       <= '0;
                            r_swapped <= 1'b0;
                        end
                    end else begin
                        r_i       <= w_i1;
                        r_swapped <= r_swapped | w_swap;
                    end
                end
                ST_DRAIN: begin
                    if (i_wr_strobe || i_start) r_err <= 1'b1;
                    if (i_rd_strobe) begin
                        if (w_last_pop) begin
                            r_count  <= '0;
                            r_rd_ptr <= '0;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Buffer storage: loads in LOAD, in-place swaps in SORT; contents survive clear.
    always_ff @(posedge i_clk) begin
        if (!i_clear) begin
            if (r_state == ST_LOAD && w_wr_ok) begin
                r_mem[r_count[AW-1:0]] <= i_wr_data;
            end
            if (r_state == ST_SORT && w_swap) begin
                r_mem[r_i]  <= w_b;
                r_mem[w_i1] <= w_a;
            end
        end
    end

    assign o_count = r_count;
    assign o_err   = r_err;

endmodule

// File: tb/tb_sort_engine.sv
module tb_sort_engine;

    localparam int W  = 8;
    localparam int D  = 10;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          reset, clear, wr, start, rd;
    logic [W-1:0]  wdat;
    logic [W-1:0]  rd_a, rd_d;
    logic [CW-1:0] cnt_a, cnt_d;
    logic          busy_a, busy_d, done_a, done_d, err_a, err_d;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the words the block should hold, and the expected error flag.
    logic [W-1:0] mq[$];
    bit           m_err;

    always #5 clk = ~clk;

    sort_engine #(.WIDTH(W), .DEPTH(D), .DESCENDING(1'b0)) u_asc (
        .i_clk(clk), .i_reset(reset), .i_clear(clear), .i_wr_strobe(wr), .i_wr_data(wdat),
        .i_start(start), .i_rd_strobe(rd), .o_rd_data(rd_a), .o_count(cnt_a),
        .o_busy(busy_a), .o_done(done_a), .o_err(err_a));

    sort_engine #(.WIDTH(W), .DEPTH(D), .DESCENDING(1'b1)) u_desc (
        .i_clk(clk), .i_reset(reset), .i_clear(clear), .i_wr_strobe(wr), .i_wr_data(wdat),
        .i_start(start), .i_rd_strobe(rd), .o_rd_data(rd_d), .o_count(cnt_d),
        .o_busy(busy_d), .o_done(done_d), .o_err(err_d));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [W-1:0] v);
        wr = 1'b1; wdat = v;
        tick();
        wr = 1'b0;
        if (mq.size() < D) mq.push_back(v);
        else m_err = 1'b1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        mq.delete();
        m_err = 1'b0;
    endtask

    // Number of compare cycles for the held words: repeated passes over a
    // shrinking prefix, stopping after a swap-free pass or the final pair.
    function automatic int model_cmps(input bit desc);
        logic [W-1:0] a[$];
        logic [W-1:0] t;
        int lim, c;
        bit sw;
        a = mq;
        if (a.size() < 2) return 0;
        lim = a.size() - 1;
        c = 0;
        while (1) begin
            sw = 1'b0;
            for (int i = 0; i < lim; i++) begin
                c++;
                if (desc ? (a[i] < a[i+1]) : (a[i] > a[i+1])) begin
                    t = a[i]; a[i] = a[i+1]; a[i+1] = t; sw = 1'b1;
                end
            end
            if (!sw || lim == 1) break;
            lim--;
        end
        return c;
    endfunction

    // Start, time the busy window on both instances, then drain and compare.
    task automatic run_sort(input string name, input bit misuse, output int o_ca, output int o_cd);
        logic [W-1:0] sa[$];
        logic [W-1:0] sd[$];
        int ea, ed, ca, cd;
        bit both;
        n_checks++;
        if (cnt_a !== CW'(mq.size()) || cnt_d !== CW'(mq.size())) begin
            n_errors++;
            $display("FAIL %s count before start: got %0d/%0d expected %0d", name, cnt_a, cnt_d, mq.size());
        end
        ea = model_cmps(1'b0);
        ed = model_cmps(1'b1);
        sa = mq; sa.sort();
        sd = mq; sd.rsort();
        start = 1'b1;
        tick();
        start = 1'b0;
        ca = 0; cd = 0; both = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if ((busy_a && done_a) || (busy_d && done_d)) both = 1'b1;
            if (!busy_a && !busy_d) break;
            if (busy_a) ca++;
            if (busy_d) cd++;
            if (misuse && c == 0) begin
                wr = 1'b1; wdat = 8'hEE; m_err = 1'b1;
            end else begin
                wr = 1'b0;
            end
            tick();
        end
        wr = 1'b0;
        o_ca = ca; o_cd = cd;
        n_checks++;
        if (ca !== ea) begin
            n_errors++;
            $display("FAIL %s asc busy cycles: got %0d expected %0d", name, ca, ea);
        end
        n_checks++;
        if (cd !== ed) begin
            n_errors++;
            $display("FAIL %s desc busy cycles: got %0d expected %0d", name, cd, ed);
        end
        n_checks++;
        if (both !== 1'b0 || done_a !== 1'b1 || done_d !== 1'b1) begin
            n_errors++;
            $display("FAIL %s done after sort: overlap=%0d done=%0d/%0d expected overlap 0 done 1/1", name, both, done_a, done_d);
        end
        for (int k = 0; k < sa.size(); k++) begin
            n_checks++;
            if (rd_a !== sa[k] || rd_d !== sd[k]) begin
                n_errors++;
                $display("FAIL %s pop %0d: got %0d/%0d expected %0d/%0d", name, k, rd_a, rd_d, sa[k], sd[k]);
            end
            rd = 1'b1;
            tick();
            rd = 1'b0;
        end
        n_checks++;
        if (cnt_a !== '0 || cnt_d !== '0 || done_a !== 1'b0 || done_d !== 1'b0 || rd_a !== '0) begin
            n_errors++;
            $display("FAIL %s after drain: count=%0d/%0d done=%0d/%0d rd=%0d expected 0", name, cnt_a, cnt_d, done_a, done_d, rd_a);
        end
        n_checks++;
        if (err_a !== m_err || err_d !== m_err) begin
            n_errors++;
            $display("FAIL %s err: got %0d/%0d expected %0d", name, err_a, err_d, m_err);
        end
        mq.delete();
    endtask

    task automatic test_reset();
        n_checks++;
        if (cnt_a !== '0 || busy_a !== 1'b0 || done_a !== 1'b0 || err_a !== 1'b0 || rd_a !== '0 ||
            cnt_d !== '0 || busy_d !== 1'b0 || done_d !== 1'b0 || err_d !== 1'b0 || rd_d !== '0) begin
            n_errors++;
            $display("FAIL reset state: count=%0d busy=%0d done=%0d err=%0d rd=%0d expected all 0", cnt_a, busy_a, done_a, err_a, rd_a);
        end
    endtask

    task automatic test_fixed_sort();
        int vals[10] = '{5, 3, 4, 5, 7, 2, 9, 6, 7, 4};
        int ca, cd;
        do_clear();
        foreach (vals[k]) do_write(W'(vals[k]));
        n_checks++;
        if (cnt_a !== CW'(10) || err_a !== 1'b0) begin
            n_errors++;
            $display("FAIL fixed load: count=%0d err=%0d expected 10 0", cnt_a, err_a);
        end
        run_sort("fixed", 1'b0, ca, cd);
    endtask

    task automatic test_early_exit();
        int ca, cd;
        do_clear();
        for (int v = 1; v <= 10; v++) do_write(W'(v));
        run_sort("sorted", 1'b0, ca, cd);
        n_checks++;
        if (ca !== 9 || cd !== 45) begin
            n_errors++;
            $display("FAIL sorted input busy: got %0d/%0d expected 9/45", ca, cd);
        end
    endtask

    task automatic test_reversed();
        int ca, cd;
        do_clear();
        for (int v = 10; v >= 1; v--) do_write(W'(v));
        run_sort("reversed", 1'b0, ca, cd);
        n_checks++;
        if (ca !== 45 || cd !== 9) begin
            n_errors++;
            $display("FAIL reversed input busy: got %0d/%0d expected 45/9", ca, cd);
        end
    endtask

    task automatic test_overflow();
        int ca, cd;
        do_clear();
        for (int v = 20; v <= 30; v++) do_write(W'(v));
        n_checks++;
        if (cnt_a !== CW'(10) || err_a !== 1'b1 || err_d !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow load: count=%0d err=%0d/%0d expected 10 1", cnt_a, err_a, err_d);
        end
        run_sort("overflow", 1'b1, ca, cd);
        do_clear();
        n_checks++;
        if (err_a !== 1'b0 || err_d !== 1'b0 || cnt_a !== '0) begin
            n_errors++;
            $display("FAIL clear after overflow: err=%0d/%0d count=%0d expected 0", err_a, err_d, cnt_a);
        end
    endtask

    task automatic test_single();
        int ca, cd;
        do_clear();
        do_write(8'd42);
        run_sort("single", 1'b0, ca, cd);
        n_checks++;
        if (ca !== 0 || cd !== 0) begin
            n_errors++;
            $display("FAIL single busy: got %0d/%0d expected 0", ca, cd);
        end
    endtask

    task automatic test_clear_drain();
        do_clear();
        for (int k = 0; k < 4; k++) do_write(W'($urandom_range(0, 255)));
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 50 && (busy_a || busy_d); c++) tick();
        rd = 1'b1; tick(); rd = 1'b0;
        do_clear();
        n_checks++;
        if (cnt_a !== '0 || done_a !== 1'b0 || busy_a !== 1'b0 || rd_a !== '0 || done_d !== 1'b0) begin
            n_errors++;
            $display("FAIL clear mid-drain: count=%0d done=%0d busy=%0d rd=%0d expected 0", cnt_a, done_a, busy_a, rd_a);
        end
    endtask

    task automatic test_reset_mid_sort();
        int ca, cd;
        do_clear();
        for (int v = 9; v >= 3; v--) do_write(W'(v));
        start = 1'b1; tick(); start = 1'b0;
        wr = 1'b1; tick(); wr = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || err_a !== 1'b0 || cnt_a !== '0 || rd_a !== '0 ||
            busy_d !== 1'b0 || err_d !== 1'b0 || cnt_d !== '0) begin
            n_errors++;
            $display("FAIL reset mid-sort: busy=%0d done=%0d err=%0d count=%0d expected 0", busy_a, done_a, err_a, cnt_a);
        end
        tick();
        reset = 1'b1;
        tick();
        mq.delete();
        m_err = 1'b0;
        do_write(8'd3); do_write(8'd1); do_write(8'd2);
        run_sort("post-reset", 1'b0, ca, cd);
    endtask

    task automatic test_random();
        int n, ca, cd;
        for (int it = 0; it < 8; it++) begin
            do_clear();
            n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) do_write(W'($urandom_range(0, 15)));
            run_sort("random", 1'b0, ca, cd);
        end
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; wr = 1'b0; start = 1'b0; rd = 1'b0; wdat = '0;
        m_err = 1'b0;
        tick();
        test_reset();
        tick();
        reset = 1'b1;
        tick();
        test_fixed_sort();
        test_early_exit();
        test_reversed();
        test_overflow();
        test_single();
        test_clear_drain();
        test_reset_mid_sort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

// File: doc/sort_engine.md
# sort_engine

Parametrised hardware sort peripheral for the jimmy CPU. It replaces the software bubble-sort loop: the CPU streams a block of unsigned values in through one strobed port, issues a start, and reads the values back in sorted order through another strobed port. It sits on the CPU I/O strobe bus alongside the other port peripherals and has configurable word width, buffer depth and sort direction.

## Interface
- `WIDTH`, 8: data word width in bits; values are unsigned.
- `DEPTH`, 10: buffer capacity in words, must be at least 2.
- `DESCENDING`, 0: 0 sorts ascending, 1 sorts descending.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous flush from any state.
- `wr_strobe` in 1: one-cycle pulse; writes `wr_data`.
- `wr_data` in WIDTH: value to load.
- `start` in 1: one-cycle pulse; begins the sort.
- `rd_strobe` in 1: one-cycle pulse; pops the current `rd_data`.
- `rd_data` out WIDTH: current sorted output word.
- `count` out $clog2(DEPTH+1): number of words held.
- `busy` out 1: high while sorting.
- `done` out 1: high while sorted data is readable.
- `err` out 1: sticky protocol-error flag.

## Operation
- The block has three states: LOAD, SORT and DRAIN.
- **LOAD**
  - `wr_strobe` with `count < DEPTH` stores `wr_data` at `mem[count]` and increments `count`.
  - `wr_strobe` with `count == DEPTH` drops the write, leaves `count` unchanged and sets `err`.
  - `start` with `count >= 2` moves to SORT and initialises `i = 0`, `limit = count-1`, `swapped = 0`.
  - `start` with `count < 2` moves directly to DRAIN.
  - If `wr_strobe` and `start` arrive in the same cycle, the write is committed first and included in the sort.
- **SORT**
  - Each cycle performs one compare/swap of `mem[i]` and `mem[i+1]`.
  - Ascending mode swaps when `mem[i] > mem[i+1]`; descending mode swaps when `mem[i] < mem[i+1]`. Equal values are never swapped.
  - When `i == limit-1` the pass ends:
    - If no swap occurred in this pass, or `limit == 1`, move to DRAIN.
    - Otherwise set `limit = limit-1`, `i = 0` and clear `swapped`.
  - `wr_strobe`, `start` and `rd_strobe` arriving during SORT are ignored and set `err`.
- **DRAIN**
  - `rd_data = mem[rd_ptr]`, driven combinationally from the registered pointer.
  - `rd_strobe` increments `rd_ptr`.
  - The strobe that pops the last word (`rd_ptr == count-1`) returns the block to LOAD with `count = 0` and `rd_ptr = 0`.
  - `wr_strobe` and `start` arriving during DRAIN are ignored and set `err`.
- `rd_data` is 0 in every state except DRAIN.
- `clear` has the highest priority. It forces LOAD with `count = 0`, `rd_ptr = 0` and `err = 0`. Buffer contents need not be zeroed.
- `err` is cleared only by `clear` or `reset`.

## Timing
- Reset values:
  - State is LOAD.
  - `count`, `rd_ptr`, `i`, `limit` and `swapped` are 0.
  - Outputs: `busy = 0`, `done = 0`, `err = 0`, `rd_data = 0`.
- An asserted `reset` during SORT or DRAIN aborts immediately and returns all state to the reset values.
- `count` updates on the edge that samples `wr_strobe`.
- **Entering and leaving SORT**
  - `start` sampled at edge k gives `busy = 1` from edge k through edge k+C.
  - C is the number of compare cycles.
  - At edge k+C, `busy` falls and `done` rises together.
- **Compare counts**
  - The worst case is C = n(n-1)/2 for n words.
  - Already-sorted input gives C = n-1.
  - For n < 2, C = 0: `done` rises at edge k and `busy` never asserts.
- `busy` and `done` are never high at the same time.
- **DRAIN read timing**
  - `rd_data` is valid in the cycle `done` rises.
  - After each `rd_strobe`, the next word is valid on the following cycle.
  - Back-to-back `rd_strobe` pulses pop one word per cycle.
  - `done` falls on the edge that pops the last word.

## Test plan
- **Ascending sort:** write 5,3,4,5,7,2,9,6,7,4, then pulse `start`.
  - `count` = 10, then `busy` asserts.
  - 10 `rd_strobe` pops yield 2,3,4,4,5,5,6,7,7,9.
  - `count` = 0, state is LOAD and `err` = 0.
- **Descending sort:** with `DESCENDING=1`, use the same input.
  - Pops yield 9,7,7,6,5,5,4,4,3,2.
- **Early exit:** write 1..10 in order, then `start`.
  - `busy` is high for exactly 9 cycles.
- **Reversed input:** write 10..1.
  - `busy` is high for exactly 45 cycles.
- **Overflow and misuse:** issue 11 writes, 20..30.
  - `count` stays 10 and `err` = 1.
  - The sort yields 20..29.
  - `wr_strobe` during SORT leaves the output unchanged and keeps `err` = 1.
  - `clear` drops `err` to 0.
- **Degenerate block sizes:**
  - A single write of 42, then `start`: `done` rises next cycle, `busy` never asserts, one pop gives 42.
  - Assert `reset` low mid-SORT: all outputs go to their reset values at once; a fresh 3-word sort (3,1,2) then completes correctly with pops 1,2,3.
